// File: rtl/mux_key_rr_arbiter.sv
// Round-robin arbiter that drives the 2-bit select key of a 4:1 mux and holds it until accepted.
// Optional build macro RR_ARB_LOCK_EN: ready with lock=1 re-grants the current key without rotating.
module mux_key_rr_arbiter (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       ready,
    input  logic       lock,
    output logic [1:0] key,
    output logic [3:0] grant,
    output logic       valid,
    output logic [1:0] ptr
);

    typedef enum logic {IDLE, GRANT} state_t;
    state_t state;

    // First set bit of r, scanning base, base+1, base+2, base+3 (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] sel;
        logic [1:0] idx;
        sel = base;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (r[idx]) sel = idx;
        end
        return sel;
    endfunction

    logic [1:0] nxt_ptr;
    logic [3:0] others;
    logic [1:0] win_idle;
    logic [1:0] win_next;
    logic       hold_lock;

    assign nxt_ptr  = key + 2'd1;
    assign others   = req & ~(4'b0001 << key);
    assign win_idle = rr_pick(req, ptr);
    assign win_next = rr_pick(others, nxt_ptr);

`ifdef RR_ARB_LOCK_EN
    assign hold_lock = lock & req[key];
`else
    logic lock_unused;
    assign lock_unused = lock;
    assign hold_lock   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            key   <= 2'b00;
            grant <= 4'b0000;
            valid <= 1'b0;
            ptr   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        key   <= win_idle;
                        grant <= 4'b0001 << win_idle;
                        valid <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // Selection is frozen until the consumer accepts; a locked accept keeps it as-is.
                    if (ready && !hold_lock) begin
                        ptr <= nxt_ptr;
                        if (|others) begin
                            key   <= win_next;
                            grant <= 4'b0001 << win_next;
                        end else if (!req[key]) begin
                            grant <= 4'b0000;
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
